// File: rtl/wb_test_slave_pkg.sv
// Shared bus widths, FSM encodings and byte-lane helper for wb_test_slave.
// The WAIT state encoding exists only when WB_SLAVE_WAIT_EN is defined.
package wb_test_slave_pkg;

    localparam int unsigned WB_DATA_BUS_WIDTH    = 32;
    localparam int unsigned WB_ADDRESS_BUS_WIDTH = 32;
    localparam int unsigned WB_BWSEL_WIDTH       = 4;
    localparam int unsigned WB_CNT_WIDTH         = 16;
    localparam int unsigned WB_WAIT_CTR_WIDTH    = 4;

`ifdef WB_SLAVE_WAIT_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } wb_state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StResp = 2'd2
    } wb_state_e;
`endif

    function automatic logic [WB_DATA_BUS_WIDTH-1:0] lane_merge(
        input logic [WB_DATA_BUS_WIDTH-1:0] old_val,
        input logic [WB_DATA_BUS_WIDTH-1:0] new_val,
        input logic [WB_BWSEL_WIDTH-1:0]    sel
    );
        logic [WB_DATA_BUS_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(WB_BWSEL_WIDTH); i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_slave_wait_ctr.sv
// Loadable 4-bit down-counter with zero flag, used to time wb_test_slave wait states.
// Counting stops at zero; load has priority over enable.
module wb_slave_wait_ctr
    import wb_test_slave_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic                         en_i,
    input  logic [WB_WAIT_CTR_WIDTH-1:0] load_val_i,
    output logic                         zero_o
);

    logic [WB_WAIT_CTR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wb_test_slave.sv
// Wishbone classic test slave: NUM_WORDS x 32-bit byte-lane registers plus write/read counters.
// Define WB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states; otherwise latency is one cycle.
module wb_test_slave
    import wb_test_slave_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                            wb_clk,
    input  logic                            wb_rst,
    input  logic [WB_ADDRESS_BUS_WIDTH-1:0] wb_addr,
    input  logic [WB_DATA_BUS_WIDTH-1:0]    wb_data_i,
    output logic [WB_DATA_BUS_WIDTH-1:0]    wb_data_o,
    input  logic [WB_BWSEL_WIDTH-1:0]       wb_bwsel,
    input  logic                            wb_cyc,
    input  logic                            wb_stb,
    input  logic                            wb_we,
    output logic                            wb_ack,
    output logic                            wb_err,
    output logic [WB_CNT_WIDTH-1:0]         wr_cnt,
    output logic [WB_CNT_WIDTH-1:0]         rd_cnt
);

    localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("WAIT_CYCLES must be in 0..15");
    end

    wb_state_e                       state_q, state_d;
    logic [WB_ADDRESS_BUS_WIDTH-1:0] addr_q, addr_d;
    logic [WB_DATA_BUS_WIDTH-1:0]    data_q, data_d;
    logic [WB_BWSEL_WIDTH-1:0]       bwsel_q, bwsel_d;
    logic                            we_q, we_d;
    logic [WB_CNT_WIDTH-1:0]         wr_cnt_q, wr_cnt_d;
    logic [WB_CNT_WIDTH-1:0]         rd_cnt_q, rd_cnt_d;
    logic [WB_DATA_BUS_WIDTH-1:0]    mem_q [NUM_WORDS];

    logic            start;
    logic            in_range;
    logic            mem_we;
    logic [IdxW-1:0] idx;

    assign start    = wb_cyc & wb_stb;
    assign in_range = (addr_q < WB_ADDRESS_BUS_WIDTH'(NUM_WORDS));
    assign idx      = addr_q[IdxW-1:0];

`ifdef WB_SLAVE_WAIT_EN
    localparam logic [WB_WAIT_CTR_WIDTH-1:0] WaitLoad =
        (WAIT_CYCLES > 0) ? WB_WAIT_CTR_WIDTH'(WAIT_CYCLES - 1) : '0;

    logic wait_load;
    logic wait_zero;

    wb_slave_wait_ctr u_wait_ctr (
        .clk_i      (wb_clk),
        .rst_i      (wb_rst),
        .load_i     (wait_load),
        .en_i       (state_q == StWait),
        .load_val_i (WaitLoad),
        .zero_o     (wait_zero)
    );
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        bwsel_d  = bwsel_q;
        we_d     = we_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        mem_we   = 1'b0;
`ifdef WB_SLAVE_WAIT_EN
        wait_load = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = wb_addr;
                    data_d  = wb_data_i;
                    bwsel_d = wb_bwsel;
                    we_d    = wb_we;
`ifdef WB_SLAVE_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d   = StWait;
                        wait_load = 1'b1;
                    end else begin
                        state_d = StResp;
                    end
`else
                    state_d = StResp;
`endif
                end
            end
`ifdef WB_SLAVE_WAIT_EN
            StWait: begin
                // Master withdrawing the strobe aborts the access without side effects.
                if (!start) begin
                    state_d = StIdle;
                end else if (wait_zero) begin
                    state_d = StResp;
                end
            end
`endif
            StResp: begin
                state_d = StIdle;
                if (in_range) begin
                    if (we_q) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= '0;
            bwsel_q  <= '0;
            we_q     <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            bwsel_q  <= bwsel_d;
            we_q     <= we_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= lane_merge(mem_q[idx], data_q, bwsel_q);
        end
    end

    assign wb_ack    = (state_q == StResp) && in_range;
    assign wb_err    = (state_q == StResp) && !in_range;
    assign wb_data_o = (wb_ack && !we_q) ? mem_q[idx] : '0;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_wb_test_slave.sv
// Self-checking bench for wb_test_slave: shadow register model feeding a response scoreboard.
// Latency expectations follow WB_SLAVE_WAIT_EN.
module tb_wb_test_slave;

    localparam int unsigned NumWords   = 16;
    localparam int unsigned WaitCycles = 2;
`ifdef WB_SLAVE_WAIT_EN
    localparam int unsigned Lat = WaitCycles + 1;
`else
    localparam int unsigned Lat = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data_i = '0;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_bwsel = '0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic        wb_ack;
    logic        wb_err;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    wb_test_slave #(
        .NUM_WORDS   (NumWords),
        .WAIT_CYCLES (WaitCycles)
    ) dut (
        .wb_clk    (clk),
        .wb_rst    (rst),
        .wb_addr   (wb_addr),
        .wb_data_i (wb_data_i),
        .wb_data_o (wb_data_o),
        .wb_bwsel  (wb_bwsel),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] model [NumWords];
    logic [15:0] exp_wr = '0;
    logic [15:0] exp_rd = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response on the bus must match the oldest outstanding expectation.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && (wb_ack || wb_err)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_resp", 32'({wb_ack, wb_err}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("resp_ack", 32'(wb_ack), 32'(e.ack));
                check_eq("resp_err", 32'(wb_err), 32'(e.err));
                check_eq("resp_rdata", wb_data_o, e.data);
            end
        end
    end

    task automatic push_expect(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input logic we);
        resp_t      e;
        logic       in_rng;
        logic [3:0] i4;
        in_rng = (addr < NumWords);
        i4     = addr[3:0];
        e.ack  = in_rng;
        e.err  = !in_rng;
        e.data = (in_rng && !we) ? model[i4] : 32'd0;
        exp_q.push_back(e);
        if (in_rng && we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) model[i4][8*b +: 8] = wdata[8*b +: 8];
            end
            exp_wr = exp_wr + 16'd1;
        end else if (in_rng) begin
            exp_rd = exp_rd + 16'd1;
        end
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            if (wb_ack || wb_err) seen = 1'b1;
            else n++;
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) check_eq({tag, "_latency"}, 32'(n), 32'(Lat));
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
        check_eq({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(exp_rd));
    endtask

    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] sel, input logic we);
        push_expect(addr, wdata, sel, we);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_addr = addr;
        wb_data_i = wdata; wb_bwsel = sel; wb_we = we;
        wait_resp("access");
        // Disturb the request fields during the response; the latched copy must win.
        wb_addr = $urandom; wb_data_i = $urandom; wb_bwsel = 4'($urandom); wb_we = ~we;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        check_eq("pulse_ackerr", 32'({wb_ack, wb_err}), 32'd0);
        check_eq("idle_rdata", wb_data_o, 32'd0);
        check_counters("access");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit expired expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < int'(NumWords); i++) model[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ackerr", 32'({wb_ack, wb_err}), 32'd0);
        check_eq("reset_rdata", wb_data_o, 32'd0);
        check_counters("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic write then read-back.
        bus_access(32'd4, 32'hDEAD_BEEF, 4'hF, 1'b1);
        bus_access(32'd4, 32'd0, 4'hF, 1'b0);

        // Single-lane update keeps the other lanes.
        bus_access(32'd2, 32'h1122_3344, 4'hF, 1'b1);
        bus_access(32'd2, 32'h00AA_0000, 4'b0100, 1'b1);
        bus_access(32'd2, 32'd0, 4'hF, 1'b0);

        // Empty byte enable still acks and counts.
        bus_access(32'd3, 32'hFFFF_FFFF, 4'h0, 1'b1);
        bus_access(32'd3, 32'd0, 4'hF, 1'b0);
        bus_access(32'd15, 32'hCAFE_0F0F, 4'b1001, 1'b1);
        bus_access(32'd15, 32'd0, 4'hF, 1'b0);

        // Out-of-range accesses: err only, no write, no count.
        bus_access(32'd16, 32'h5555_5555, 4'hF, 1'b1);
        bus_access(32'd16, 32'd0, 4'hF, 1'b0);
        bus_access(32'hFFFF_FFFF, 32'd0, 4'hF, 1'b0);

        // Back-to-back reads with the strobe held across the response.
        push_expect(32'd4, 32'd0, 4'hF, 1'b0);
        push_expect(32'd2, 32'd0, 4'hF, 1'b0);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'd4; wb_bwsel = 4'hF;
        wait_resp("b2b_first");
        wb_addr = 32'd2;
        wait_resp("b2b_second");
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        check_counters("b2b");

`ifdef WB_SLAVE_WAIT_EN
        // Strobe withdrawn after one wait cycle: nothing happens.
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 32'd4;
        wb_data_i = 32'h0BAD_0BAD; wb_bwsel = 4'hF;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (6) @(negedge clk);
        check_counters("abort");
        bus_access(32'd4, 32'd0, 4'hF, 1'b0);
`endif

        // Write counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.wr_cnt_q = 16'hFFFE;
        #1 release dut.wr_cnt_q;
        exp_wr = 16'hFFFE;
        @(negedge clk);
        check_eq("preload_wr_cnt", 32'(wr_cnt), 32'h0000_FFFE);
        bus_access(32'd6, 32'h0000_0001, 4'hF, 1'b1);
        bus_access(32'd6, 32'h0000_0002, 4'hF, 1'b1);
        check_eq("wrap_wr_cnt", 32'(wr_cnt), 32'd0);

        // Reset during an in-flight write, bus held active through reset.
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 32'd5;
        wb_data_i = 32'h1234_5678; wb_bwsel = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_ackerr", 32'({wb_ack, wb_err}), 32'd0);
        check_eq("rst_rdata", wb_data_o, 32'd0);
        for (int i = 0; i < int'(NumWords); i++) model[i] = '0;
        exp_wr = '0;
        exp_rd = '0;
        check_counters("rst");
        @(posedge clk); #1;
        rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        bus_access(32'd5, 32'd0, 4'hF, 1'b0);
        bus_access(32'd4, 32'd0, 4'hF, 1'b0);

        repeat (4) @(negedge clk);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
